// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation full-search sequencer:
// FSM state encoding, SAD width helper and the initial best-SAD value.
package me_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SCAN  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_FIN   = 3'd4
   } me_state_t;

   // Wide enough for the largest legal block; users slice it to SADW.
   localparam logic [31:0] SAD_INIT = 32'hFFFF_FFFF;

   function automatic int sad_width(input int blk);
      return 8 + 2 * $clog2(blk);
   endfunction

endpackage

// File: rtl/me_best_sel.sv
// Running minimum of candidate SADs with the motion vector decoded from the
// raster-order receive index; strict less-than keeps the earliest tie.
module me_best_sel
   import me_pkg::*;
#(
   parameter int SADW = 12,
   parameter int CW   = 2
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              valid,
   input  logic [SADW-1:0]   sad,
   input  logic [2*CW-1:0]   idx,
   output logic [SADW-1:0]   best_sad,
   output logic [CW-1:0]     mv_x,
   output logic [CW-1:0]     mv_y
);

   // Best-candidate register: cleared per search, updated on a strictly smaller SAD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         best_sad <= {SADW{1'b0}};
         mv_x     <= {CW{1'b0}};
         mv_y     <= {CW{1'b0}};
      end else if (clr) begin
         best_sad <= SAD_INIT[SADW-1:0];
         mv_x     <= {CW{1'b0}};
         mv_y     <= {CW{1'b0}};
      end else if (valid && (sad < best_sad)) begin
         best_sad <= sad;
         mv_x     <= idx[CW-1:0];
         mv_y     <= idx[2*CW-1:CW];
      end
   end

endmodule

// File: rtl/me_search_ctrl.sv
// Full-search sequencer: loads the current block, scans every candidate of the
// search window row by row, and tracks the minimum returned SAD.
module me_search_ctrl
   import me_pkg::*;
#(
   parameter int  BLK  = 8,
   parameter int  SW   = 16,
   localparam int SADW = sad_width(BLK),
   localparam int RW   = $clog2(BLK),
   localparam int CW   = $clog2(SW),
   localparam int PRW  = $clog2(SW + BLK)
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              crt_keep,
   output logic              crt_rd_en,
   output logic [RW-1:0]     crt_row,
   output logic              pre_rd_en,
   output logic [PRW-1:0]    pre_row,
   output logic [CW-1:0]     pre_col,
   input  logic              sad_valid_i,
   input  logic [SADW-1:0]   sad_i,
   output logic [SADW-1:0]   best_sad,
   output logic [CW-1:0]     mv_x,
   output logic [CW-1:0]     mv_y
);

   localparam int              CNTW     = 2 * CW + 1;
   localparam logic [CNTW-1:0] RCV_FULL = CNTW'(SW * SW);
   localparam logic [RW-1:0]   BLK_LAST = RW'(BLK - 1);
   localparam logic [CW-1:0]   SW_LAST  = CW'(SW - 1);

   me_state_t         state_r, state_s;
   logic [RW-1:0]     row_r, row_s;
   logic [CW-1:0]     sx_r, sx_s;
   logic [CW-1:0]     sy_r, sy_s;
   logic [CNTW-1:0]   rcv_r, rcv_s;
   logic              accept_s;
   logic              clr_s;

   // Next-state, candidate counters and receive counter.
   always_comb begin
      state_s  = state_r;
      row_s    = row_r;
      sx_s     = sx_r;
      sy_s     = sy_r;
      clr_s    = 1'b0;
      accept_s = sad_valid_i && (rcv_r != RCV_FULL) &&
                 ((state_r == ST_LOAD) || (state_r == ST_SCAN) || (state_r == ST_DRAIN));
      if (accept_s) begin
         rcv_s = rcv_r + CNTW'(1);
      end else begin
         rcv_s = rcv_r;
      end
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s = ST_LOAD;
               row_s   = {RW{1'b0}};
               sx_s    = {CW{1'b0}};
               sy_s    = {CW{1'b0}};
               rcv_s   = {CNTW{1'b0}};
               clr_s   = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (row_r == BLK_LAST) begin
               state_s = ST_SCAN;
               row_s   = {RW{1'b0}};
            end else begin
               row_s   = row_r + RW'(1);
            end
         end
         ST_SCAN: begin
            // The last candidate leaves its counters parked instead of wrapping.
            if (row_r == BLK_LAST) begin
               if (sx_r == SW_LAST) begin
                  if (sy_r == SW_LAST) begin
                     state_s = ST_DRAIN;
                  end else begin
                     row_s = {RW{1'b0}};
                     sx_s  = {CW{1'b0}};
                     sy_s  = sy_r + CW'(1);
                  end
               end else begin
                  row_s = {RW{1'b0}};
                  sx_s  = sx_r + CW'(1);
               end
            end else begin
               row_s = row_r + RW'(1);
            end
         end
         ST_DRAIN: begin
            if (rcv_s == RCV_FULL) begin
               state_s = ST_FIN;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         ST_FIN: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         row_r   <= {RW{1'b0}};
         sx_r    <= {CW{1'b0}};
         sy_r    <= {CW{1'b0}};
         rcv_r   <= {CNTW{1'b0}};
      end else begin
         state_r <= state_s;
         row_r   <= row_s;
         sx_r    <= sx_s;
         sy_r    <= sy_s;
         rcv_r   <= rcv_s;
      end
   end

   // Registered strobes and addresses, decoded from the next state so they
   // line up with the state they belong to; crt_keep trails the read by one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         crt_keep  <= 1'b1;
         crt_rd_en <= 1'b0;
         crt_row   <= {RW{1'b0}};
         pre_rd_en <= 1'b0;
         pre_row   <= {PRW{1'b0}};
         pre_col   <= {CW{1'b0}};
      end else begin
         busy      <= (state_s != ST_IDLE);
         done      <= (state_s == ST_FIN);
         crt_keep  <= ~crt_rd_en;
         crt_rd_en <= (state_s == ST_LOAD);
         crt_row   <= (state_s == ST_LOAD) ? row_s : {RW{1'b0}};
         pre_rd_en <= (state_s == ST_SCAN);
         pre_row   <= (state_s == ST_SCAN) ? (PRW'(sy_s) + PRW'(row_s)) : {PRW{1'b0}};
         pre_col   <= (state_s == ST_SCAN) ? sx_s : {CW{1'b0}};
      end
   end

   me_best_sel #(
      .SADW (SADW),
      .CW   (CW)
   ) u_best_sel (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr_s),
      .valid    (accept_s),
      .sad      (sad_i),
      .idx      (rcv_r[2*CW-1:0]),
      .best_sad (best_sad),
      .mv_x     (mv_x),
      .mv_y     (mv_y)
   );

endmodule

// File: tb/tb_me_search_ctrl.sv
// Bench for me_search_ctrl at BLK=4, SW=4: an adder-tree model returns SADs
// with latency 3 and a result scoreboard is checked at each done.
module tb_me_search_ctrl;

   localparam int BLK   = 4;
   localparam int SW    = 4;
   localparam int NCAND = SW * SW;
   localparam int LAT   = 3;

   logic        clk, rst_n, start;
   logic        busy, done, crt_keep, crt_rd_en, pre_rd_en;
   logic [1:0]  crt_row;
   logic [2:0]  pre_row;
   logic [1:0]  pre_col;
   logic        sad_valid_i;
   logic [11:0] sad_i, best_sad;
   logic [1:0]  mv_x, mv_y;

   typedef struct { int due; logic [11:0] v; } rsp_t;
   typedef struct { logic [11:0] best; logic [1:0] mx; logic [1:0] my; } res_t;
   typedef struct {
      int kind; int extra; bit inject; bit timing;
      logic [11:0] best; logic [1:0] mx; logic [1:0] my;
   } vec_t;

   rsp_t rsp_q[$];
   res_t exp_q[$];
   vec_t vecs[5];

   int cyc = 0;
   int n_cmp = 0, n_fail = 0;
   int sad_kind = 0, extra_n = 0;
   int keep_cnt = 0, keep_first = -1, crt_cnt = 0, crt_err = 0;
   int pre_cnt = 0, pre_first = -1, pre_err = 0, done_cnt = 0;
   int m_n, m_r;

   me_search_ctrl #(.BLK(BLK), .SW(SW)) dut (
      .clk (clk), .rst_n (rst_n), .start (start), .busy (busy), .done (done),
      .crt_keep (crt_keep), .crt_rd_en (crt_rd_en), .crt_row (crt_row),
      .pre_rd_en (pre_rd_en), .pre_row (pre_row), .pre_col (pre_col),
      .sad_valid_i (sad_valid_i), .sad_i (sad_i),
      .best_sad (best_sad), .mv_x (mv_x), .mv_y (mv_y)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, required summary before time limit");
      $fatal(1);
   end

   function automatic logic [11:0] sad_of(input int kind, input int idx);
      case (kind)
         0: return 12'(100 - idx);
         1: return ((idx == 5) || (idx == 9)) ? 12'd10 : 12'(100 - idx);
         2: return 12'd255;
         3: return (idx == 6) ? 12'd7 : 12'(200 + idx);
         4: return (idx == 15) ? 12'd4079 : 12'd4080;
         default: return 12'd0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   // Adder-tree model and address monitors, all sampled on the falling edge.
   initial begin
      sad_valid_i = 1'b0;
      sad_i = 12'd0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            rsp_q.delete();
            sad_valid_i = 1'b0;
            sad_i = 12'd0;
         end else begin
            if (!crt_keep) begin
               if (keep_cnt == 0) keep_first = cyc;
               keep_cnt++;
            end
            if (crt_rd_en) begin
               if (crt_row != 2'(crt_cnt)) crt_err++;
               crt_cnt++;
            end
            if (pre_rd_en) begin
               m_n = pre_cnt / BLK;
               m_r = pre_cnt % BLK;
               if (pre_cnt == 0) pre_first = cyc;
               if ((pre_row != 3'(m_n / SW + m_r)) || (pre_col != 2'(m_n % SW))) pre_err++;
               pre_cnt++;
               if (m_r == BLK - 1) begin
                  rsp_q.push_back('{due: cyc + LAT, v: sad_of(sad_kind, m_n)});
                  if (m_n == NCAND - 1) begin
                     for (int e = 0; e < extra_n; e++)
                        rsp_q.push_back('{due: cyc + LAT + 1 + e, v: 12'd1});
                  end
               end
            end
            if (done) done_cnt++;
            if ((rsp_q.size() > 0) && (rsp_q[0].due == cyc)) begin
               sad_valid_i = 1'b1;
               sad_i = rsp_q[0].v;
               void'(rsp_q.pop_front());
            end else begin
               sad_valid_i = 1'b0;
            end
         end
      end
   end

   task automatic check_reset(input string tag);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_busy"}, busy, 0);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_crt_keep"}, crt_keep, 1);
      chk({tag, "_crt_rd_en"}, crt_rd_en, 0);
      chk({tag, "_pre_rd_en"}, pre_rd_en, 0);
      chk({tag, "_crt_row"}, crt_row, 0);
      chk({tag, "_pre_row"}, pre_row, 0);
      chk({tag, "_pre_col"}, pre_col, 0);
      chk({tag, "_best_sad"}, best_sad, 0);
      chk({tag, "_mv_x"}, mv_x, 0);
      chk({tag, "_mv_y"}, mv_y, 0);
   endtask

   task automatic run_search(input vec_t v);
      bit   got;
      int   t0;
      res_t e;
      sad_kind = v.kind;  extra_n = v.extra;
      keep_cnt = 0; keep_first = -1; crt_cnt = 0; crt_err = 0;
      pre_cnt = 0; pre_first = -1; pre_err = 0; done_cnt = 0;
      exp_q.push_back('{best: v.best, mx: v.mx, my: v.my});
      start = 1'b1;
      t0 = cyc;
      got = 1'b0;
      for (int k = 0; (k < 500) && !got; k++) begin
         @(negedge clk);
         start = (v.inject && (pre_cnt == 30)) ? 1'b1 : 1'b0;
         if (done) got = 1'b1;
      end
      start = 1'b0;
      chk("done_seen", got, 1);
      e = exp_q.pop_front();
      if (got) begin
         chk("best_sad", best_sad, e.best);
         chk("mv_x", mv_x, e.mx);
         chk("mv_y", mv_y, e.my);
         chk("done_cycle", cyc, t0 + BLK + NCAND * BLK + LAT + 1);
         chk("busy_at_done", busy, 1);
      end
      repeat (8) @(negedge clk);
      chk("done_count", done_cnt, 1);
      chk("best_hold", best_sad, e.best);
      chk("busy_idle", busy, 0);
      if (v.timing) begin
         chk("keep_low_cycles", keep_cnt, BLK);
         chk("keep_first_cycle", keep_first, t0 + 2);
         chk("crt_rows", crt_cnt, BLK);
         chk("crt_row_err", crt_err, 0);
         chk("pre_first_cycle", pre_first, t0 + BLK + 1);
         chk("pre_cycles", pre_cnt, NCAND * BLK);
         chk("pre_addr_err", pre_err, 0);
      end
   endtask

   initial begin
      vecs[0] = '{kind: 0, extra: 0, inject: 1'b0, timing: 1'b1, best: 12'd85,   mx: 2'd3, my: 2'd3};
      vecs[1] = '{kind: 1, extra: 0, inject: 1'b0, timing: 1'b0, best: 12'd10,   mx: 2'd1, my: 2'd1};
      vecs[2] = '{kind: 2, extra: 0, inject: 1'b0, timing: 1'b0, best: 12'd255,  mx: 2'd0, my: 2'd0};
      vecs[3] = '{kind: 3, extra: 4, inject: 1'b1, timing: 1'b1, best: 12'd7,    mx: 2'd2, my: 2'd1};
      vecs[4] = '{kind: 4, extra: 0, inject: 1'b0, timing: 1'b0, best: 12'd4079, mx: 2'd3, my: 2'd3};

      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals("rst");
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) run_search(vecs[i]);

      // Reset in the middle of a scan, then a clean restart.
      sad_kind = 0; extra_n = 0; pre_cnt = 0; done_cnt = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; (k < 200) && (pre_cnt < 20); k++) @(negedge clk);
      chk("mid_in_scan", pre_rd_en, 1);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("mid");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      chk("mid_no_done", done_cnt, 0);
      run_search(vecs[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/me_search_ctrl.md
# me_search_ctrl

Sequencer for the motion-estimation PE array in full-search mode. It loads one BLK×BLK current-frame block into the array by driving `crt_keep` low for BLK cycles. It then streams previous-frame rows for every candidate position in an SW×SW search window. It collects the per-candidate SAD returned by the adder tree downstream of the PEs and reports the minimum SAD with its motion vector.

## Interface
- `BLK`, 8: block edge in pixels; power of two, 4..16
- `SW`, 16: candidate positions per axis; power of two, 2..64
- `SADW`, 8+2*$clog2(BLK): SAD width; derived, not overridden
- `clk` in 1: single clock, all logic on posedge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle request to search a block; honoured only in IDLE
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse when results are final
- `crt_keep` out 1: to all PEs; 0 = capture the current pixel, 1 = hold
- `crt_rd_en` out 1: current-frame buffer read strobe
- `crt_row` out $clog2(BLK): current-block row address
- `pre_rd_en` out 1: previous-frame buffer read strobe
- `pre_row` out $clog2(SW+BLK): window row address (sy+r)
- `pre_col` out $clog2(SW): window column offset (sx)
- `sad_valid_i` in 1: adder tree presents one candidate SAD
- `sad_i` in SADW: SAD of the oldest outstanding candidate
- `best_sad` out SADW: minimum SAD; valid from `done` until the next `start`
- `mv_x`, `mv_y` out $clog2(SW) each: candidate index (sx, sy) of `best_sad`

## Operation
- States: IDLE, LOAD, SCAN, DRAIN, FIN.
- IDLE, with `start`=1: go to LOAD. Clear the candidate-issue counter and the SAD-receive counter. Set `best_sad` to all-ones and `mv_x`/`mv_y` to 0.
- LOAD: lasts BLK cycles.
  - `crt_rd_en`=1; `crt_row` counts 0..BLK-1.
  - `crt_keep`=0 for these BLK cycles, delayed by one cycle to match buffer read latency. It is 1 at all other times, including reset.
  - After the last row, go to SCAN.
- SCAN: raster order over candidates, sy outer and sx inner, 0..SW-1 each.
  - Each candidate takes BLK cycles with `pre_rd_en`=1, `pre_row`=sy+r (r=0..BLK-1) and `pre_col`=sx.
  - After candidate (SW-1, SW-1), go to DRAIN.
- DRAIN: wait until the receive counter reaches SW*SW, then go to FIN.
- FIN: pulse `done` for one cycle, then return to IDLE.
- Every `sad_valid_i`=1 in LOAD, SCAN or DRAIN:
  - Increment the receive counter.
  - If `sad_i` < `best_sad` (strict), capture `sad_i` and set (`mv_x`, `mv_y`) to the receive counter decoded as (cnt mod SW, cnt / SW).
  - On ties the earliest candidate in raster order wins.
- `sad_valid_i` in IDLE or FIN is ignored. Extra valids after SW*SW SADs have been received are ignored.
- `start` while `busy`=1 is ignored; there is no queueing.
- Asynchronous reset in any state:
  - State returns to IDLE; all counters and addresses go to 0.
  - `busy`, `done`, `crt_rd_en` and `pre_rd_en` go to 0; `crt_keep` goes to 1.
  - `best_sad`, `mv_x` and `mv_y` go to 0. An interrupted search produces no `done`.

## Timing
- `start` sampled in cycle 0:
  - LOAD occupies cycles 1..BLK.
  - SCAN occupies cycles BLK+1..BLK+SW*SW*BLK.
  - DRAIN follows for however many cycles the adder-tree latency requires.
  - `done` rises one cycle after the last SAD is received.
- All outputs are registered; addresses and strobes change only on clock edges.
- Counter wrap: `pre_col` wraps SW-1→0 on the final row of a candidate, and sy increments on that same cycle. Counters never wrap past the last candidate.
- If the final `sad_valid_i` lands in the last SCAN cycle, DRAIN lasts exactly one cycle.

## Structure
- Shared package `me_pkg`:
  - state enum `me_state_t`
  - function `sad_width(blk)`
  - all-ones initial-SAD constant
- One sub-module, `me_best_sel`: holds `best_sad`/`mv_x`/`mv_y`, does the strict-less comparison and the index decode. It has its own clear input driven from IDLE→LOAD.
- The FSM and address counters live in the top.

## Test plan
- BLK=4, SW=4, `sad_i` = 100 minus the candidate index, returned with latency 3 → `best_sad`=85, `mv`=(3,3), `done` in the cycle after the 16th valid.
- Same stream except candidate 5 returns SAD 10 and candidate 9 also returns 10 → `best_sad`=10, `mv`=(1,1); the tie keeps the first.
- Check `crt_keep` is low for exactly 4 cycles, starting at cycle 2. Check `pre_row` sweeps 0..3, 1..4, 2..5, 3..6 across sy, and `pre_col` holds per candidate.
- `start` pulsed during SCAN → no effect; exactly one `done`. 20 valids sent → the extra 4 are ignored.
- `rst_n` asserted mid-SCAN → outputs take their reset values immediately, no `done` appears, and a fresh `start` completes normally.
- All 16 SADs = 255 (max for BLK=4 is 4080) → `best_sad`=255, `mv`=(0,0).
